// File: rtl/pipe_front_stall_ctrl_if.sv
// pipe_front_stall_ctrl_if: request/fetch inputs and pipeline register outputs of the front-end stall controller
interface pipe_front_stall_ctrl_if #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
);
  logic              start_i;
  logic              stall_i;
  logic              flush_i;
  logic [31:0]       branch_target_i;
  logic [31:0]       instr_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [31:0]       pc_o;
  logic [31:0]       if_id_pc_o;
  logic [31:0]       if_id_instr_o;
  logic              if_id_valid_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  modport master (
    output start_i, stall_i, flush_i, branch_target_i, instr_i, ctrl_i,
    input  pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, ex_ctrl_o, stall_cnt_o, flush_cnt_o
  );
  modport slave (
    input  start_i, stall_i, flush_i, branch_target_i, instr_i, ctrl_i,
    output pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, ex_ctrl_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_front_stall_ctrl.sv
// pipe_front_stall_ctrl: PC, IF/ID and ID/EX control registers reacting to load-use stall and ID branch flush
module pipe_front_stall_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 8,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic clk_i,
  input logic rst_i,
  pipe_front_stall_ctrl_if.slave bus
);
  logic [31:0]       pc, if_id_pc, if_id_instr;
  logic              if_id_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              stall_e, flush_e;
  // an unresolved branch (load-use dependent operands) cannot redirect, so stall wins
  assign stall_e = bus.start_i & bus.stall_i;
  assign flush_e = bus.start_i & bus.flush_i & ~bus.stall_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pc          <= RESET_PC;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      ex_ctrl     <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      pc <= (!bus.start_i || stall_e) ? pc : flush_e ? bus.branch_target_i : pc + 32'd4;
      if (!stall_e) begin
        if_id_instr <= (bus.start_i && !flush_e) ? bus.instr_i : NOP_INSTR;
        if_id_valid <= bus.start_i & ~flush_e;
        if_id_pc    <= bus.start_i ? pc : if_id_pc;
      end
      ex_ctrl <= (stall_e || !if_id_valid || !bus.start_i) ? '0 : bus.ctrl_i;
      if (stall_e && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_e && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  assign bus.pc_o          = pc;
  assign bus.if_id_pc_o    = if_id_pc;
  assign bus.if_id_instr_o = if_id_instr;
  assign bus.if_id_valid_o = if_id_valid;
  assign bus.ex_ctrl_o     = ex_ctrl;
  assign bus.stall_cnt_o   = stall_cnt;
  assign bus.flush_cnt_o   = flush_cnt;
endmodule

// File: tb/tb_pipe_front_stall_ctrl.sv
// tb_pipe_front_stall_ctrl: directed vector table plus saturation and async-reset sequences
module tb_pipe_front_stall_ctrl;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pipe_front_stall_ctrl_if #(.CTRL_W(8), .CNT_W(16)) bus ();
  pipe_front_stall_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  assign bus.instr_i = 32'h1000_0000 | bus.pc_o;
  typedef struct {
    logic        start, stall, flush;
    logic [31:0] tgt;
    logic [7:0]  ctrl;
    logic [31:0] pc, ifpc, instr;
    logic        v;
    logic [7:0]  ex;
    logic [15:0] sc, fc;
  } vec_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  vec_t tv [21];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic chk_all(input string t, input logic [31:0] pc, ifpc, instr, input logic v,
                         input logic [7:0] ex, input logic [15:0] sc, fc);
    chk({t, " pc"}, bus.pc_o, pc);
    chk({t, " if_id_pc"}, bus.if_id_pc_o, ifpc);
    chk({t, " if_id_instr"}, bus.if_id_instr_o, instr);
    chk({t, " if_id_valid"}, 32'(bus.if_id_valid_o), 32'(v));
    chk({t, " ex_ctrl"}, 32'(bus.ex_ctrl_o), 32'(ex));
    chk({t, " stall_cnt"}, 32'(bus.stall_cnt_o), 32'(sc));
    chk({t, " flush_cnt"}, 32'(bus.flush_cnt_o), 32'(fc));
  endtask
  initial begin
    //        start stall flush tgt           ctrl   pc            ifpc          instr         v  ex     sc        fc
    tv[0]  = '{1, 0, 0, 32'h0,        8'h11, 32'h4,        32'h0,        32'h1000_0000, 1, 8'h00, 16'd0, 16'd0};
    tv[1]  = '{1, 0, 0, 32'h0,        8'h12, 32'h8,        32'h4,        32'h1000_0004, 1, 8'h12, 16'd0, 16'd0};
    tv[2]  = '{1, 0, 0, 32'h0,        8'h13, 32'hC,        32'h8,        32'h1000_0008, 1, 8'h13, 16'd0, 16'd0};
    tv[3]  = '{1, 0, 0, 32'h0,        8'h14, 32'h10,       32'hC,        32'h1000_000C, 1, 8'h14, 16'd0, 16'd0};
    tv[4]  = '{1, 1, 0, 32'h0,        8'h15, 32'h10,       32'hC,        32'h1000_000C, 1, 8'h00, 16'd1, 16'd0};
    tv[5]  = '{1, 1, 0, 32'h0,        8'h16, 32'h10,       32'hC,        32'h1000_000C, 1, 8'h00, 16'd2, 16'd0};
    tv[6]  = '{1, 0, 0, 32'h0,        8'h17, 32'h14,       32'h10,       32'h1000_0010, 1, 8'h17, 16'd2, 16'd0};
    tv[7]  = '{1, 0, 0, 32'h0,        8'h18, 32'h18,       32'h14,       32'h1000_0014, 1, 8'h18, 16'd2, 16'd0};
    tv[8]  = '{1, 0, 0, 32'h0,        8'h19, 32'h1C,       32'h18,       32'h1000_0018, 1, 8'h19, 16'd2, 16'd0};
    tv[9]  = '{1, 0, 0, 32'h0,        8'h1A, 32'h20,       32'h1C,       32'h1000_001C, 1, 8'h1A, 16'd2, 16'd0};
    tv[10] = '{1, 0, 1, 32'h100,      8'h1B, 32'h100,      32'h20,       NOP,           0, 8'h1B, 16'd2, 16'd1};
    tv[11] = '{1, 0, 0, 32'h0,        8'h1C, 32'h104,      32'h100,      32'h1000_0100, 1, 8'h00, 16'd2, 16'd1};
    tv[12] = '{1, 0, 0, 32'h0,        8'h1D, 32'h108,      32'h104,      32'h1000_0104, 1, 8'h1D, 16'd2, 16'd1};
    tv[13] = '{1, 1, 1, 32'h200,      8'h1E, 32'h108,      32'h104,      32'h1000_0104, 1, 8'h00, 16'd3, 16'd1};
    tv[14] = '{1, 0, 1, 32'h200,      8'h1F, 32'h200,      32'h108,      NOP,           0, 8'h1F, 16'd3, 16'd2};
    tv[15] = '{0, 1, 1, 32'h300,      8'h20, 32'h200,      32'h108,      NOP,           0, 8'h00, 16'd3, 16'd2};
    tv[16] = '{0, 0, 0, 32'h0,        8'h21, 32'h200,      32'h108,      NOP,           0, 8'h00, 16'd3, 16'd2};
    tv[17] = '{1, 0, 0, 32'h0,        8'h22, 32'h204,      32'h200,      32'h1000_0200, 1, 8'h00, 16'd3, 16'd2};
    tv[18] = '{1, 0, 1, 32'hFFFF_FFFC, 8'h23, 32'hFFFF_FFFC, 32'h204,      NOP,           0, 8'h23, 16'd3, 16'd3};
    tv[19] = '{1, 0, 0, 32'h0,        8'h24, 32'h0,        32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 8'h00, 16'd3, 16'd3};
    tv[20] = '{1, 0, 0, 32'h0,        8'h25, 32'h4,        32'h0,        32'h1000_0000, 1, 8'h25, 16'd3, 16'd3};
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.branch_target_i = '0;
    bus.ctrl_i = '0;
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 32'h0, 32'h0, NOP, 1'b0, 8'h00, 16'd0, 16'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      bus.start_i = tv[i].start;
      bus.stall_i = tv[i].stall;
      bus.flush_i = tv[i].flush;
      bus.branch_target_i = tv[i].tgt;
      bus.ctrl_i = tv[i].ctrl;
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), tv[i].pc, tv[i].ifpc, tv[i].instr, tv[i].v, tv[i].ex, tv[i].sc, tv[i].fc);
    end
    // stall count is 3; 65532 more stall cycles reach all-ones, then one extra must not wrap
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b0;
    bus.ctrl_i = 8'h55;
    repeat (65532) @(posedge clk);
    #1 chk("sat reach", 32'(bus.stall_cnt_o), 32'h0000_FFFF);
    @(posedge clk);
    #1 chk_all("sat hold", 32'h4, 32'h0, 32'h1000_0000, 1'b1, 8'h00, 16'hFFFF, 16'd3);
    @(negedge clk) bus.stall_i = 1'b0;
    repeat (15) @(posedge clk);
    #1 chk("run to 0x40", bus.pc_o, 32'h40);
    @(negedge clk) bus.stall_i = 1'b1;
    @(posedge clk);
    #1 chk("stall at 0x40", bus.pc_o, 32'h40);
    #2 rst = 1'b1;
    #1 chk_all("async rst", 32'h0, 32'h0, NOP, 1'b0, 8'h00, 16'd0, 16'd0);
    @(negedge clk) begin
      rst = 1'b0;
      bus.stall_i = 1'b0;
    end
    @(posedge clk);
    #1 chk_all("post rst", 32'h4, 32'h0, 32'h1000_0000, 1'b1, 8'h00, 16'd0, 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_front_stall_ctrl.md
Name: pipe_front_stall_ctrl

Overview:
- Consumer side of the load-use hazard handshake in the 5-stage RISC-V pipeline.
- Owns the PC register, the IF/ID pipeline register and the control field of the ID/EX register, and acts on the stall and flush requests.
- Holds the PC and IF/ID on stall, inserts an ID/EX control bubble, and squashes IF/ID on a taken branch resolved in ID.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CTRL_W, 8, width of the decoded ID control bundle
CNT_W, 16, width of each event counter
NOP_INSTR, 32'h0000_0013, instruction word written into IF/ID on squash or idle (addi x0,x0,0)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  run enable; low freezes PC and feeds bubbles
stall_i  in  1  load-use stall request from hazard detection
flush_i  in  1  branch taken, resolved in ID this cycle
branch_target_i  in  32  target PC for a taken branch
instr_i  in  32  instruction memory read data for address pc_o (combinational fetch)
ctrl_i  in  CTRL_W  decoded control of the instruction currently in ID
pc_o  out  32  current fetch PC
if_id_pc_o  out  32  PC of the instruction held in IF/ID
if_id_instr_o  out  32  instruction held in IF/ID
if_id_valid_o  out  1  IF/ID holds a real instruction
ex_ctrl_o  out  CTRL_W  registered ID/EX control; all zero means bubble
stall_cnt_o  out  CNT_W  accepted stall cycles, saturating
flush_cnt_o  out  CNT_W  accepted flush cycles, saturating

Behaviour:
Reset:
- rst_i high asynchronously forces pc_o=RESET_PC, if_id_pc_o=0, if_id_instr_o=NOP_INSTR, if_id_valid_o=0, ex_ctrl_o=0, both counters 0.
- Reset has effect mid-stall or mid-flush; no pending state survives it.

Effective requests, evaluated each rising edge:
- stall_e = start_i & stall_i.
- flush_e = start_i & flush_i & ~stall_i. Stall has priority: a branch whose operands are load-use dependent is not yet resolved, so flush_i in the same cycle is ignored.

PC update:
- start_i=0: hold.
- stall_e: hold.
- flush_e: branch_target_i.
- Otherwise: pc_o+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).

IF/ID update:
- stall_e: hold all three fields.
- flush_e: instr=NOP_INSTR, valid=0, pc=pc_o.
- start_i=0: instr=NOP_INSTR, valid=0, pc held.
- Otherwise: instr=instr_i, pc=pc_o, valid=1.

ID/EX control:
- ex_ctrl_o = 0 if stall_e, or ~if_id_valid_o, or start_i=0.
- Otherwise ex_ctrl_o = ctrl_i.
- A flush does not bubble ID/EX: the branch itself proceeds to EX.

Counters:
- stall_cnt_o += 1 on each stall_e cycle.
- flush_cnt_o += 1 on each flush_e cycle.
- Each holds at all-ones once reached; no wrap.

Timing:
- Latency is one cycle from a request to the register effect.
- A stall held for N cycles freezes PC and IF/ID for exactly N edges and inserts N bubbles into EX.
- No combinational path from stall_i or flush_i to any output.

Test Plan:
- Reset release, start_i=1, instr_i tracks pc_o, 4 cycles -> pc_o 0,4,8,12,16; IF/ID valid from cycle 1 with pc 0,4,8,12; ex_ctrl_o=ctrl_i from cycle 2.
- stall_i=1 for 2 cycles at pc_o=0x10 -> pc_o stays 0x10 for 2 edges; IF/ID instr held; ex_ctrl_o=0 for 2 cycles; stall_cnt_o=2; fetch resumes at 0x14.
- flush_i=1, branch_target_i=0x100 at pc_o=0x20 -> next pc_o=0x100; if_id_valid_o=0, if_id_instr_o=0x0000_0013; ex_ctrl_o=ctrl_i (not bubbled); flush_cnt_o=1.
- stall_i=1 and flush_i=1 together -> PC and IF/ID held, ex_ctrl_o=0, stall_cnt_o+1, flush_cnt_o unchanged; flush_i alone next cycle redirects PC.
- pc_o=0xFFFF_FFFC, no stall or flush -> pc_o=0x0000_0000; stall_cnt_o preloaded to 0xFFFF by 65535 stall cycles, then one more stall -> stays 0xFFFF.
- rst_i asserted asynchronously mid-stall with pc_o=0x40 -> outputs reset immediately, before the next edge; pc_o=RESET_PC, counters 0.
